butterfly_sequencer: RTL and testbench
======================================

BUTTERFLY_SEQUENCER -- requirements
Module: butterfly_sequencer

Interface
REQ-001 SHALL have parameter LOG2N, default 4, meaning log2 of DFT point count N (N = 16 by default).
REQ-002 SHALL have parameter PIPE, default 2, meaning cycles from read issue to write-back (1 RAM read plus 1 butterfly register); legal range 1..7.
REQ-003 SHALL have port i_CLK  input  1  rising-edge clock.
REQ-004 SHALL have port i_RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_START  input  1  request to run a full in-place transform.
REQ-006 SHALL have port o_BUSY  output  1  high whenever state is not IDLE.
REQ-007 SHALL have port o_DONE  output  1  one-cycle completion pulse.
REQ-008 SHALL have port o_RD_EN  output  1  read both butterfly operands this cycle.
REQ-009 SHALL have port o_RD_ADDR_A / o_RD_ADDR_B  output  LOG2N each  operand addresses.
REQ-010 SHALL have port o_TW_IDX  output  LOG2N-1  twiddle ROM index, aligned with o_RD_EN.
REQ-011 SHALL have port o_WR_EN  output  1  write both butterfly results (i_A+..., i_A-...) this cycle.
REQ-012 SHALL have port o_WR_ADDR_A / o_WR_ADDR_B  output  LOG2N each  write-back addresses.
REQ-013 SHALL have port o_STAGE  output  ceil(log2(LOG2N))  current stage number s.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE -> RUN on edge with i_START=1; i_START in any other state SHALL be ignored (no queueing).
REQ-016 RUN SHALL issue one butterfly per cycle, k = 0..N/2-1, o_RD_EN=1 every RUN cycle.
REQ-017 Address rules per issue: half = 2^s, pos = k mod half, grp = k div half; A = grp*2*half + pos; B = A + half; o_TW_IDX = pos << (LOG2N-1-s); all unsigned, no wrap possible.
REQ-018 After issuing k = N/2-1, RUN -> DRAIN; DRAIN SHALL last exactly PIPE cycles with o_RD_EN=0.
REQ-019 DRAIN end: if s < LOG2N-1 then s <= s+1, k <= 0, -> RUN; else -> DONE.
REQ-020 DONE SHALL last one cycle with o_DONE=1, then -> IDLE; o_DONE=0 in all other states.
REQ-021 o_WR_EN / o_WR_ADDR_A / o_WR_ADDR_B SHALL equal o_RD_EN / o_RD_ADDR_A / o_RD_ADDR_B delayed exactly PIPE cycles (shift pipeline).
REQ-022 Last write of stage s SHALL occur in the final DRAIN cycle; first read of stage s+1 SHALL occur the next cycle (no read-before-write hazard).
REQ-023 Timing for defaults: i_START sampled at edge 0; first read cycle 1; each stage 8 issue + 2 drain = 10 cycles; o_DONE high in cycle 41; o_BUSY high cycles 1..41.
REQ-024 o_RD_ADDR_*, o_TW_IDX SHALL be 0 when o_RD_EN=0; write addresses SHALL be 0 when o_WR_EN=0.
REQ-025 Input data SHALL already be in bit-reversed order in memory; block performs no reordering.

Reset
REQ-026 i_RST=1 at an edge SHALL force state IDLE, s=0, k=0, pipeline valid bits cleared, all outputs 0, overriding i_START.
REQ-027 Reset mid-RUN or mid-DRAIN SHALL suppress all pending writes from the next cycle on; no o_DONE pulse.
REQ-028 First edge after i_RST deasserts SHALL honour i_START=1.

Verification
REQ-029 Single run, defaults: pulse i_START -> 32 read issues, 32 writes, o_DONE only in cycle 41, o_BUSY low cycle 42.
REQ-030 Address check: stage 0 -> (A,B,tw) = (0,1,0),(2,3,0)..(14,15,0); stage 1 k=0..3 -> (0,2,0),(1,3,4),(4,6,0),(5,7,4); stage 3 -> (k,k+8,k).
REQ-031 Write alignment: every o_WR_EN pair matches read pair from 2 cycles earlier; stage 1 first read exactly one cycle after stage 0 final write.
REQ-032 i_START held high throughout run -> exactly one transform; restart begins on cycle 42 edge (IDLE), first read cycle 43.
REQ-033 i_RST asserted in cycle 15 (stage 1 RUN) -> cycle 16 all outputs 0, no further o_WR_EN, no o_DONE; fresh i_START then completes normally.
REQ-034 PIPE=3, LOG2N=3 -> 3 stages of 4 issues + 3 drain, o_DONE in cycle 22.

Source files
------------

// File: rtl/butterfly_sequencer.sv
// Address sequencer for an in-place radix-2 DIT FFT. Data is expected in bit-reversed order.
// Issues one butterfly read per cycle and replays the same addresses as writes PIPE cycles later.
module butterfly_sequencer #(
    parameter int  LOG2N = 4,
    parameter int  PIPE  = 2,
    localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_START,
    output logic             o_BUSY,
    output logic             o_DONE,
    output logic             o_RD_EN,
    output logic [LOG2N-1:0] o_RD_ADDR_A,
    output logic [LOG2N-1:0] o_RD_ADDR_B,
    output logic [LOG2N-2:0] o_TW_IDX,
    output logic             o_WR_EN,
    output logic [LOG2N-1:0] o_WR_ADDR_A,
    output logic [LOG2N-1:0] o_WR_ADDR_B,
    output logic [SW-1:0]    o_STAGE
);
    localparam int KW = LOG2N - 1;
    localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [2:0]    D_LAST = 3'(PIPE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [SW-1:0]   s_q, s_d;
    logic [2:0]      drain_q, drain_d;

    logic [LOG2N-1:0] k_ext, half, pos, base;
    logic             rd_en_d, rd_en_q;
    logic [LOG2N-1:0] rd_a_d, rd_a_q, rd_b_d, rd_b_q;
    logic [KW-1:0]    tw_d, tw_q;
    logic             busy_q, done_q;

    logic             wen_pipe_q [PIPE];
    logic [LOG2N-1:0] wa_pipe_q  [PIPE];
    logic [LOG2N-1:0] wb_pipe_q  [PIPE];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (i_START) begin
                    state_d = RUN;
                    k_d     = '0;
                    s_d     = '0;
                end
            end
            RUN: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == D_LAST) begin
                    if (s_q != S_LAST) begin
                        s_d     = s_q + 1'b1;
                        k_d     = '0;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                s_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Butterfly k of stage s: low s bits of k select the position, the rest the group.
    always_comb begin
        k_ext   = {1'b0, k_d};
        half    = LOG2N'(1) << s_d;
        pos     = k_ext & (half - LOG2N'(1));
        base    = ((k_ext >> s_d) << s_d) << 1;
        rd_en_d = 1'b0;
        rd_a_d  = '0;
        rd_b_d  = '0;
        tw_d    = '0;
        if (state_d == RUN) begin
            rd_en_d = 1'b1;
            rd_a_d  = base | pos;
            rd_b_d  = base | pos | half;
            tw_d    = KW'(pos << (S_LAST - s_d));
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= IDLE;
            k_q     <= '0;
            s_q     <= '0;
            drain_q <= '0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < PIPE; i++) begin
                wen_pipe_q[i] <= 1'b0;
                wa_pipe_q[i]  <= '0;
                wb_pipe_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
            drain_q <= drain_d;
            rd_en_q <= rd_en_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            tw_q    <= tw_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            // Stage 0 holds the read issued last cycle, so the tail lags reads by PIPE.
            wen_pipe_q[0] <= rd_en_q;
            wa_pipe_q[0]  <= rd_a_q;
            wb_pipe_q[0]  <= rd_b_q;
            for (int i = 1; i < PIPE; i++) begin
                wen_pipe_q[i] <= wen_pipe_q[i-1];
                wa_pipe_q[i]  <= wa_pipe_q[i-1];
                wb_pipe_q[i]  <= wb_pipe_q[i-1];
            end
        end
    end

    assign o_BUSY      = busy_q;
    assign o_DONE      = done_q;
    assign o_RD_EN     = rd_en_q;
    assign o_RD_ADDR_A = rd_a_q;
    assign o_RD_ADDR_B = rd_b_q;
    assign o_TW_IDX    = tw_q;
    assign o_WR_EN     = wen_pipe_q[PIPE-1];
    assign o_WR_ADDR_A = wa_pipe_q[PIPE-1];
    assign o_WR_ADDR_B = wb_pipe_q[PIPE-1];
    assign o_STAGE     = s_q;

endmodule

// File: tb/tb_butterfly_sequencer.sv
// Bench for butterfly_sequencer: default instance (N=16, PIPE=2) plus a LOG2N=3, PIPE=3 instance.
// Expected outputs per cycle come from a closed-form schedule of the whole transform.
module tb_butterfly_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start3 = 1'b0;

    logic       d_busy, d_done, d_rd_en, d_wr_en;
    logic [3:0] d_ra, d_rb, d_wa, d_wb;
    logic [2:0] d_tw;
    logic [1:0] d_stage;

    logic       t_busy, t_done, t_rd_en, t_wr_en;
    logic [2:0] t_ra, t_rb, t_wa, t_wb;
    logic [1:0] t_tw;
    logic [1:0] t_stage;

    int n_total = 0;
    int n_pass  = 0;
    int rd_cnt  = 0;
    int wr_cnt  = 0;

    typedef struct {
        logic [31:0] en, a, b, tw, wen, wa, wb, busy, done, stage;
        bit          chk_stage;
    } obs_t;

    butterfly_sequencer dut (
        .i_CLK(clk), .i_RST(rst), .i_START(start),
        .o_BUSY(d_busy), .o_DONE(d_done), .o_RD_EN(d_rd_en),
        .o_RD_ADDR_A(d_ra), .o_RD_ADDR_B(d_rb), .o_TW_IDX(d_tw),
        .o_WR_EN(d_wr_en), .o_WR_ADDR_A(d_wa), .o_WR_ADDR_B(d_wb),
        .o_STAGE(d_stage)
    );

    butterfly_sequencer #(.LOG2N(3), .PIPE(3)) dut3 (
        .i_CLK(clk), .i_RST(rst), .i_START(start3),
        .o_BUSY(t_busy), .o_DONE(t_done), .o_RD_EN(t_rd_en),
        .o_RD_ADDR_A(t_ra), .o_RD_ADDR_B(t_rb), .o_TW_IDX(t_tw),
        .o_WR_EN(t_wr_en), .o_WR_ADDR_A(t_wa), .o_WR_ADDR_B(t_wb),
        .o_STAGE(t_stage)
    );

    always #5 clk = ~clk;

    // Read issued in cycle c of a run (cycle 1 = first read); zeros outside the issue windows.
    function automatic void rd_at(input int c, input int lg, input int pipe,
                                  output logic [31:0] en, output logic [31:0] a,
                                  output logic [31:0] b, output logic [31:0] tw);
        int issues, per, total, st, off, half, pos, grp;
        issues = 2 ** (lg - 1);
        per    = issues + pipe;
        total  = lg * per;
        en = 0; a = 0; b = 0; tw = 0;
        if (c >= 1 && c <= total) begin
            st  = (c - 1) / per;
            off = (c - 1) % per;
            if (off < issues) begin
                half = 2 ** st;
                pos  = off % half;
                grp  = off / half;
                en   = 1;
                a    = grp * 2 * half + pos;
                b    = a + half;
                tw   = pos * (issues / half);
            end
        end
    endfunction

    function automatic obs_t model(input int c, input int lg, input int pipe);
        obs_t e;
        logic [31:0] unused_tw;
        int per, total;
        per   = 2 ** (lg - 1) + pipe;
        total = lg * per;
        rd_at(c, lg, pipe, e.en, e.a, e.b, e.tw);
        rd_at(c - pipe, lg, pipe, e.wen, e.wa, e.wb, unused_tw);
        e.busy      = (c >= 1 && c <= total + 1) ? 1 : 0;
        e.done      = (c == total + 1) ? 1 : 0;
        e.chk_stage = (c >= 1 && c <= total);
        e.stage     = e.chk_stage ? (c - 1) / per : 0;
        return e;
    endfunction

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: got %0d expected %0d", tag, c, obs, exp);
    endtask

    task automatic check_dut(input int c, input int lg, input int pipe, input int which);
        obs_t e, o;
        string p;
        e = model(c, lg, pipe);
        if (which == 0) begin
            p = "n16.";
            o.en = 32'(d_rd_en); o.a = 32'(d_ra); o.b = 32'(d_rb); o.tw = 32'(d_tw);
            o.wen = 32'(d_wr_en); o.wa = 32'(d_wa); o.wb = 32'(d_wb);
            o.busy = 32'(d_busy); o.done = 32'(d_done); o.stage = 32'(d_stage);
            if (d_rd_en === 1'b1) rd_cnt++;
            if (d_wr_en === 1'b1) wr_cnt++;
        end else begin
            p = "n8p3.";
            o.en = 32'(t_rd_en); o.a = 32'(t_ra); o.b = 32'(t_rb); o.tw = 32'(t_tw);
            o.wen = 32'(t_wr_en); o.wa = 32'(t_wa); o.wb = 32'(t_wb);
            o.busy = 32'(t_busy); o.done = 32'(t_done); o.stage = 32'(t_stage);
        end
        o.chk_stage = 1'b0;
        chk({p, "rd_en"}, c, o.en, e.en);
        chk({p, "rd_a"}, c, o.a, e.a);
        chk({p, "rd_b"}, c, o.b, e.b);
        chk({p, "tw"}, c, o.tw, e.tw);
        chk({p, "wr_en"}, c, o.wen, e.wen);
        chk({p, "wr_a"}, c, o.wa, e.wa);
        chk({p, "wr_b"}, c, o.wb, e.wb);
        chk({p, "busy"}, c, o.busy, e.busy);
        chk({p, "done"}, c, o.done, e.done);
        if (e.chk_stage) chk({p, "stage"}, c, o.stage, e.stage);
    endtask

    // Caller raises start before edge 0; start drops at the negedge of cycle drop_at.
    task automatic run_default(input int ncyc, input int drop_at);
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c >= drop_at) start = 1'b0;
            check_dut(c, 4, 2, 0);
        end
    endtask

    initial begin
        int hold, r;
        // Reset state
        repeat (3) @(negedge clk);
        check_dut(0, 4, 2, 0);
        check_dut(0, 3, 3, 1);
        rst = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);

        // Single transform, start held for a random number of cycles
        hold = $urandom_range(1, 41);
        $display("run1: start held %0d cycles", hold);
        rd_cnt = 0;
        wr_cnt = 0;
        start = 1'b1;
        run_default(45, hold);
        chk("n16.read_count", 45, 32'(rd_cnt), 32'd32);
        chk("n16.write_count", 45, 32'(wr_cnt), 32'd32);

        // Start held through the run: one transform, restart from the IDLE cycle 42
        $display("run2: start held high, restart expected at cycle 43");
        start = 1'b1;
        run_default(42, 43);
        run_default(45, 1);

        // Reset during a run: cycle 15 first, then a random cycle
        for (int rep = 0; rep < 2; rep++) begin
            r = (rep == 0) ? 15 : $urandom_range(2, 41);
            $display("run3.%0d: reset in cycle %0d", rep, r);
            start = 1'b1;
            run_default(r, 1);
            rst = 1'b1;
            start = 1'b1;
            @(negedge clk);
            check_dut(0, 4, 2, 0);
            rst = 1'b0;
            start = 1'b0;
            for (int j = 0; j < 12; j++) begin
                @(negedge clk);
                check_dut(0, 4, 2, 0);
            end
        end

        // Start present during reset is overridden, then honoured on the first free edge
        $display("run4: start through reset release");
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_dut(0, 4, 2, 0);
        rst = 1'b0;
        run_default(45, 1);

        // LOG2N=3, PIPE=3 instance: done expected in cycle 22
        $display("run5: LOG2N=3 PIPE=3");
        start3 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            start3 = 1'b0;
            check_dut(c, 3, 3, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
